// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP multiplier normalise/round/pack stage.
package fpmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ROUND = 3'd2,
    PACK  = 3'd3,
    DONE  = 3'd4
  } fpmul_post_state_t;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_ZERO = 2'b11;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

endpackage

// File: rtl/fpmul_rne_round.sv
// Mantissa rounding increment. With FPMUL_POST_RNE_EN defined it rounds to
// nearest, ties to even; otherwise it truncates (increment forced to 0).
module fpmul_rne_round (
  input  logic [23:0] m_in,
  input  logic        g,
  input  logic        s,
  output logic [23:0] m_out,
  output logic        carry
);

  logic        inc;
  logic [24:0] sum;

`ifdef FPMUL_POST_RNE_EN
  assign inc = g & (s | m_in[0]);
`else
  logic unused_rnd;
  assign unused_rnd = g ^ s;
  assign inc        = 1'b0;
`endif

  assign sum   = {1'b0, m_in} + {24'd0, inc};
  assign carry = sum[24];
  // A carry out means the mantissa wrapped from all-ones; renormalise to 1.0.
  assign m_out = carry ? 24'h800000 : sum[23:0];

endmodule

// File: rtl/fpmul_post.sv
// Normalise/round/pack stage of the binary32 multiplier. Rounding mode is
// selected by FPMUL_POST_RNE_EN (defined: nearest-even, undefined: truncate).
module fpmul_post
  import fpmul_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTK,
  input  logic        BACK,
  input  logic [47:0] res,
  input  logic        sign_in,
  input  logic [9:0]  exp_sum,
  input  logic        zero_in,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [1:0]  exc,
  output logic        drop_err,
  output logic [2:0]  state_dbg
);

  // Output handshake: result/exc are presented with out_valid and held
  // unchanged until a cycle where out_valid && out_ready; that cycle is the
  // transfer, and out_valid drops on the following edge.

  localparam logic signed [10:0] E_OVF  = FP_EXP_MAX[10:0];
  localparam logic signed [10:0] E_ZERO = 11'sd0;
  localparam logic signed [10:0] E_ONE  = 11'sd1;

  fpmul_post_state_t  state_q, state_d;
  logic [47:0]        p_q, p_d;
  logic               sign_q, sign_d;
  logic signed [10:0] e_q, e_d;
  logic               zero_q, zero_d;
  logic [23:0]        m_q, m_d;
  logic               g_q, g_d;
  logic               s_q, s_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        result_q, result_d;
  logic [1:0]         exc_q, exc_d;
  logic               drop_err_q, drop_err_d;

  logic [23:0]        m_rnd;
  logic               carry_rnd;
  logic               unused_hidden;

  fpmul_rne_round u_round (
    .m_in  (m_q),
    .g     (g_q),
    .s     (s_q),
    .m_out (m_rnd),
    .carry (carry_rnd)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    sign_d      = sign_q;
    e_d         = e_q;
    zero_d      = zero_q;
    m_d         = m_q;
    g_d         = g_q;
    s_d         = s_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    exc_d       = exc_q;
    drop_err_d  = drop_err_q;

    // Any pulse outside IDLE is lost, including one that coincides with the
    // DONE handshake.
    if (BACK && (state_q != IDLE)) drop_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (BACK) begin
          p_d     = res;
          sign_d  = sign_in;
          e_d     = {exp_sum[9], exp_sum};
          zero_d  = zero_in;
          busy_d  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (p_q[47]) begin
          m_d = p_q[47:24];
          g_d = p_q[23];
          s_d = |p_q[22:0];
          e_d = e_q + E_ONE;
        end else begin
          m_d = p_q[46:23];
          g_d = p_q[22];
          s_d = |p_q[21:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        m_d = m_rnd;
        if (carry_rnd) e_d = e_q + E_ONE;
        state_d = PACK;
      end
      PACK: begin
        if (zero_q) begin
          result_d = {sign_q, 31'd0};
          exc_d    = EXC_ZERO;
        end else if (e_q >= E_OVF) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          exc_d    = EXC_OVF;
        end else if (e_q <= E_ZERO) begin
          result_d = {sign_q, 31'd0};
          exc_d    = EXC_UNF;
        end else begin
          result_d = {sign_q, e_q[7:0], m_q[22:0]};
          exc_d    = EXC_NONE;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTK) begin
    if (!RSTK) begin
      state_q     <= IDLE;
      p_q         <= 48'd0;
      sign_q      <= 1'b0;
      e_q         <= 11'sd0;
      zero_q      <= 1'b0;
      m_q         <= 24'd0;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      exc_q       <= 2'b00;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      sign_q      <= sign_d;
      e_q         <= e_d;
      zero_q      <= zero_d;
      m_q         <= m_d;
      g_q         <= g_d;
      s_q         <= s_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // The hidden bit is implied by the packed format.
  assign unused_hidden = m_q[23];

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign exc       = exc_q;
  assign drop_err  = drop_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fpmul_post.sv
// Directed bench for fpmul_post: vector table plus backpressure, drop and
// reset-in-flight sequences.
module tb_fpmul_post;

`ifdef FPMUL_POST_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic [47:0] res;
    logic [9:0]  exp_sum;
    logic        sign;
    logic        zero;
    logic [31:0] exp_result;
    logic [1:0]  exp_exc;
  } vec_t;

  localparam int NV = 17;

  logic        CLK = 1'b0;
  logic        RSTK;
  logic        BACK;
  logic [47:0] res;
  logic        sign_in;
  logic [9:0]  exp_sum;
  logic        zero_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  exc;
  logic        drop_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[NV];

  fpmul_post dut (
    .CLK       (CLK),
    .RSTK      (RSTK),
    .BACK      (BACK),
    .res       (res),
    .sign_in   (sign_in),
    .exp_sum   (exp_sum),
    .zero_in   (zero_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exc       (exc),
    .drop_err  (drop_err),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] r, input logic [9:0] e, input logic s,
                              input logic z, input logic [31:0] er, input logic [1:0] ex);
    vec_t v;
    v.res = r; v.exp_sum = e; v.sign = s; v.zero = z; v.exp_result = er; v.exp_exc = ex;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one capture pulse; leaves the bench in cycle 1 (NORM).
  task automatic issue(input vec_t v);
    res = v.res; exp_sum = v.exp_sum; sign_in = v.sign; zero_in = v.zero;
    BACK = 1'b1;
    exp_q.push_back(v.exp_result);
    tick();
    BACK = 1'b0;
  endtask

  task automatic drive_junk();
    res = 48'hC000_0000_0001; exp_sum = 10'd5; sign_in = 1'b0; zero_in = 1'b0;
    BACK = 1'b1;
  endtask

  // Full transaction; drop_cyc 1..3 injects a stray pulse in that cycle.
  task automatic run_vec(input vec_t v, input int drop_cyc);
    logic [31:0] exp_r;
    issue(v);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("pre_valid_c%0d", k), {30'd0, out_valid, busy}, 32'd1);
      if (k == drop_cyc) drive_junk();
      tick();
      BACK = 1'b0;
    end
    exp_r = exp_q.pop_front();
    check("valid_at_c4", {31'd0, out_valid}, 32'd1);
    check("result", result, exp_r);
    check("exc", {30'd0, exc}, {30'd0, v.exp_exc});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_hs", {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 32'h3F80_0000, 2'b00);
    vecs[1]  = mk(48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 32'h4010_0000, 2'b00);
    vecs[2]  = mk(48'h4000_0040_0000, 10'd127, 1'b0, 1'b0, 32'h3F80_0000, 2'b00);
    vecs[3]  = mk(48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0,
                  RNE ? 32'h3F80_0002 : 32'h3F80_0001, 2'b00);
    vecs[4]  = mk(48'h4000_0060_0000, 10'd127, 1'b0, 1'b0,
                  RNE ? 32'h3F80_0001 : 32'h3F80_0000, 2'b00);
    vecs[5]  = mk(48'h7FFF_FFC0_0000, 10'd127, 1'b0, 1'b0,
                  RNE ? 32'h4000_0000 : 32'h3FFF_FFFF, 2'b00);
    vecs[6]  = mk(48'h8000_0000_0000, 10'd254, 1'b1, 1'b0, 32'hFF80_0000, 2'b01);
    vecs[7]  = mk(48'h4000_0000_0000, 10'd0,   1'b0, 1'b0, 32'h0000_0000, 2'b10);
    vecs[8]  = mk(48'h4000_0000_0000, 10'd127, 1'b1, 1'b1, 32'h8000_0000, 2'b11);
    vecs[9]  = mk(48'h4000_0000_0000, 10'd1,   1'b0, 1'b0, 32'h0080_0000, 2'b00);
    vecs[10] = mk(48'h8000_0000_0000, 10'd253, 1'b0, 1'b0, 32'h7F00_0000, 2'b00);
    vecs[11] = mk(48'h7FFF_FFC0_0000, 10'd254, 1'b0, 1'b0,
                  RNE ? 32'h7F80_0000 : 32'h7F7F_FFFF, RNE ? 2'b01 : 2'b00);
    vecs[12] = mk(48'h4000_0000_0000, 10'h381, 1'b1, 1'b0, 32'h8000_0000, 2'b10);
    vecs[13] = mk(48'h8000_0000_0000, 10'd0,   1'b0, 1'b0, 32'h0080_0000, 2'b00);
    vecs[14] = mk(48'h4000_0000_0000, 10'd381, 1'b0, 1'b1, 32'h0000_0000, 2'b11);
    vecs[15] = mk(48'h8000_0080_0001, 10'd127, 1'b0, 1'b0,
                  RNE ? 32'h4000_0001 : 32'h4000_0000, 2'b00);
    vecs[16] = mk(48'h8000_0080_0000, 10'd127, 1'b0, 1'b0, 32'h4000_0000, 2'b00);

    RSTK = 1'b0; BACK = 1'b0; res = 48'd0; sign_in = 1'b0; exp_sum = 10'd0;
    zero_in = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_result", result, 32'd0);
    check("rst_flags", {27'd0, busy, out_valid, exc, drop_err}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    RSTK = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < NV; i++) run_vec(vecs[i], 0);
    check("no_drop_yet", {31'd0, drop_err}, 32'd0);

    // Stray pulse during NORM: captured data must be unaffected
    run_vec(vecs[3], 1);
    check("drop_norm_flag", {31'd0, drop_err}, 32'd1);

    // Reset during ROUND clears everything, then normal operation resumes
    issue(vecs[0]);
    void'(exp_q.pop_back());
    tick();
    check("in_round", {29'd0, state_dbg}, 32'd2);
    #2 RSTK = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {27'd0, busy, out_valid, exc, drop_err}, 32'd0);
    check("midrst_state", {29'd0, state_dbg}, 32'd0);
    tick();
    RSTK = 1'b1;
    tick();
    run_vec(vecs[1], 0);

    // Pulse coincident with the DONE handshake is dropped and flagged
    issue(vecs[0]);
    void'(exp_q.pop_back());
    tick(); tick(); tick();
    check("hs_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drive_junk();
    tick();
    out_ready = 1'b0; BACK = 1'b0;
    check("hs_drop_idle", {29'd0, busy, out_valid, drop_err}, 32'd1);
    check("hs_drop_state", {29'd0, state_dbg}, 32'd0);
    tick();
    check("hs_drop_stay_idle", {30'd0, busy, out_valid}, 32'd0);

    // Backpressure for 5 cycles, then a stray pulse while in DONE
    v = vecs[6];
    issue(v);
    void'(exp_q.pop_back());
    tick(); tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_%0d", k), result, v.exp_result);
      check($sformatf("bp_flags_%0d", k), {30'd0, busy, out_valid}, 32'd3);
      tick();
    end
    drive_junk();
    tick();
    BACK = 1'b0;
    check("done_drop_result", result, v.exp_result);
    check("done_drop_exc", {30'd0, exc}, {30'd0, v.exp_exc});
    check("done_drop_flags", {29'd0, busy, out_valid, drop_err}, 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {30'd0, busy, out_valid}, 32'd0);

    run_vec(vecs[5], 0);
    check("drop_sticky", {31'd0, drop_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
